// File: rtl/cdma_stripe_mux_pkg.sv
// Shared types and platform constants for the striped CDMA read reassembly path.
package cdma_stripe_mux_pkg;

  localparam int N_MEM_CHAN      = 4;
  localparam int N_MEM_CHAN_BITS = $clog2(N_MEM_CHAN);
  localparam int AXI_DATA_BITS   = 512;
  localparam int LEN_BITS        = 28;
  localparam int BLEN_BITS       = LEN_BITS - $clog2(AXI_DATA_BITS / 8);

  // One sequence entry from the stripe request adjuster.
  typedef struct packed {
    logic                       ctl;
    logic [N_MEM_CHAN_BITS-1:0] vfid;
    logic [BLEN_BITS-1:0]       len;
  } stripe_seq_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } stripe_fsm_t;

endpackage

// File: rtl/cdma_stripe_skid.sv
// Two-entry AXI-stream register slice over {tdata, tkeep, tlast}.
// Input ready comes from registered occupancy only, so downstream ready
// never reaches the upstream ready combinationally.
module cdma_stripe_skid
  import cdma_stripe_mux_pkg::*;
#(
  parameter int DATA_BITS = AXI_DATA_BITS
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [DATA_BITS-1:0]   in_tdata_i,
  input  logic [DATA_BITS/8-1:0] in_tkeep_i,
  input  logic                   in_tlast_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [DATA_BITS-1:0]   out_tdata_o,
  output logic [DATA_BITS/8-1:0] out_tkeep_o,
  output logic                   out_tlast_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i
);

  localparam int W = DATA_BITS + DATA_BITS / 8 + 1;

  logic [W-1:0] ent_q [2];
  logic [W-1:0] ent_d [2];
  logic         wptr_q, wptr_d;
  logic         rptr_q, rptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         wr, rd;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign {out_tlast_o, out_tkeep_o, out_tdata_o} = ent_q[rptr_q];

  assign wr = in_valid_i && in_ready_o;
  assign rd = out_valid_o && out_ready_i;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    ent_d  = ent_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr) begin
      ent_d[wptr_q] = {in_tlast_i, in_tkeep_i, in_tdata_i};
      wptr_d        = ~wptr_q;
    end
    if (rd) begin
      rptr_d = ~rptr_q;
    end
    case ({wr, rd})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared too so the merged stream reads all-zero after reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      ent_q  <= ent_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/cdma_stripe_mux.sv
// Merges N_CHAN striped channel read streams into one AXI stream in
// beat-interleaved order starting at the request's vfid channel, and
// pulses done for every completed request that asked for a completion.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a sequence entry; s_mux_ready high
// XFER  | pulling len+1 beats, one per channel in turn from ptr onward
module cdma_stripe_mux
  import cdma_stripe_mux_pkg::*;
#(
  parameter int N_CHAN    = N_MEM_CHAN,
  parameter int DATA_BITS = AXI_DATA_BITS,
  parameter int BLEN_BITS = LEN_BITS - $clog2(DATA_BITS / 8)
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       s_mux_valid,
  output logic                       s_mux_ready,
  input  logic                       s_mux_ctl,
  input  logic [$clog2(N_CHAN)-1:0]  s_mux_vfid,
  input  logic [BLEN_BITS-1:0]       s_mux_len,
  output logic                       s_mux_done,
  input  logic [DATA_BITS-1:0]       s_axis_chan_tdata  [N_CHAN],
  input  logic [DATA_BITS/8-1:0]     s_axis_chan_tkeep  [N_CHAN],
  input  logic                       s_axis_chan_tlast  [N_CHAN],
  input  logic                       s_axis_chan_tvalid [N_CHAN],
  output logic                       s_axis_chan_tready [N_CHAN],
  output logic [DATA_BITS-1:0]       m_axis_tdata,
  output logic [DATA_BITS/8-1:0]     m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready
);

  localparam int CHAN_BITS = $clog2(N_CHAN);

  stripe_fsm_t           state_q, state_d;
  logic [CHAN_BITS-1:0]  ptr_q, ptr_d;
  logic [BLEN_BITS-1:0]  cnt_q, cnt_d;
  logic                  ctl_q, ctl_d;
  logic                  done_q, done_d;

  logic                  skid_in_valid;
  logic                  skid_in_ready;
  logic                  skid_in_tlast;
  logic [DATA_BITS-1:0]  skid_in_tdata;
  logic [DATA_BITS/8-1:0] skid_in_tkeep;

  // Channel tlast is meaningless after striping; the request length is authoritative.
  logic [N_CHAN-1:0]     chan_tlast_unused;

  always_comb begin
    for (int i = 0; i < N_CHAN; i++) begin
      chan_tlast_unused[i] = s_axis_chan_tlast[i];
    end
  end

  // Next-state, channel select and sequence handshake.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    ctl_d         = ctl_q;
    done_d        = 1'b0;
    s_mux_ready   = 1'b0;
    skid_in_valid = 1'b0;
    skid_in_tlast = (cnt_q == '0);
    skid_in_tdata = s_axis_chan_tdata[ptr_q];
    skid_in_tkeep = s_axis_chan_tkeep[ptr_q];
    for (int i = 0; i < N_CHAN; i++) begin
      s_axis_chan_tready[i] = (state_q == XFER) && skid_in_ready &&
                              (ptr_q == CHAN_BITS'(i));
    end
    case (state_q)
      IDLE: begin
        s_mux_ready = !areset;
        if (s_mux_valid) begin
          ptr_d   = s_mux_vfid;
          cnt_d   = s_mux_len;
          ctl_d   = s_mux_ctl;
          state_d = XFER;
        end
      end
      XFER: begin
        skid_in_valid = s_axis_chan_tvalid[ptr_q];
        if (skid_in_valid && skid_in_ready) begin
          ptr_d = ptr_q + CHAN_BITS'(1);
          cnt_d = cnt_q - BLEN_BITS'(1);
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = ctl_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request registers and the registered completion pulse.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ctl_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      done_q  <= done_d;
    end
  end

  assign s_mux_done = done_q;

  cdma_stripe_skid #(
    .DATA_BITS (DATA_BITS)
  ) u_skid (
    .aclk        (aclk),
    .areset      (areset),
    .in_tdata_i  (skid_in_tdata),
    .in_tkeep_i  (skid_in_tkeep),
    .in_tlast_i  (skid_in_tlast),
    .in_valid_i  (skid_in_valid),
    .in_ready_o  (skid_in_ready),
    .out_tdata_o (m_axis_tdata),
    .out_tkeep_o (m_axis_tkeep),
    .out_tlast_o (m_axis_tlast),
    .out_valid_o (m_axis_tvalid),
    .out_ready_i (m_axis_tready)
  );

endmodule

// File: tb/tb_cdma_stripe_mux.sv
// Directed bench for cdma_stripe_mux with a channel-data scoreboard.
module tb_cdma_stripe_mux;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int BL = 8;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          s_mux_valid = 1'b0;
  logic          s_mux_ready;
  logic          s_mux_ctl = 1'b0;
  logic [1:0]    s_mux_vfid = 2'd0;
  logic [BL-1:0] s_mux_len = '0;
  logic          s_mux_done;
  logic [DW-1:0] ch_tdata  [NC];
  logic [KW-1:0] ch_tkeep  [NC];
  logic          ch_tlast  [NC];
  logic          ch_tvalid [NC];
  logic          ch_tready [NC];
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [NC-1:0] trdy_vec;

  always #5 aclk = ~aclk;

  assign trdy_vec = {ch_tready[3], ch_tready[2], ch_tready[1], ch_tready[0]};

  cdma_stripe_mux #(
    .N_CHAN    (NC),
    .DATA_BITS (DW),
    .BLEN_BITS (BL)
  ) dut (
    .aclk               (aclk),
    .areset             (areset),
    .s_mux_valid        (s_mux_valid),
    .s_mux_ready        (s_mux_ready),
    .s_mux_ctl          (s_mux_ctl),
    .s_mux_vfid         (s_mux_vfid),
    .s_mux_len          (s_mux_len),
    .s_mux_done         (s_mux_done),
    .s_axis_chan_tdata  (ch_tdata),
    .s_axis_chan_tkeep  (ch_tkeep),
    .s_axis_chan_tlast  (ch_tlast),
    .s_axis_chan_tvalid (ch_tvalid),
    .s_axis_chan_tready (ch_tready),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tkeep       (m_axis_tkeep),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready)
  );

  typedef struct packed {
    logic          ctl;
    logic [1:0]    vfid;
    logic [BL-1:0] len;
  } req_t;

  req_t          seq[$];
  logic [DW-1:0] chq [NC][$];
  logic [36:0]   expq[$];
  logic [15:0]   widx [NC];
  logic          pop_pend [NC];
  logic          trdy_seen [NC];

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  bit   gaps = 1'b0;
  bit   rnd_rdy = 1'b0;
  int   act_left = 0;
  int   act_len = 0;
  bit   act_ctl = 1'b0;
  int   exp_done_cyc = -1;
  int   done_cnt = 0;
  int   beats = 0;
  int   pops = 0;
  int   first_pop_cyc = -1;
  int   last_pop_cyc = -1;
  int   first_mval_cyc = -1;
  int   b2b_acc_cyc = -1;
  int   b2b_prev_last = -1;
  bit   prev_stall = 1'b0;
  logic [36:0] prev_word = '0;

  function automatic logic [KW-1:0] keep_of(input int c);
    logic [KW-1:0] k;
    k = '1;
    return k >> c;
  endfunction

  task automatic push_req(input bit ctl, input int vfid, input int len);
    req_t r;
    r.ctl  = ctl;
    r.vfid = 2'(vfid);
    r.len  = BL'(len);
    seq.push_back(r);
    for (int k = 0; k <= len; k++) begin
      int c;
      logic [DW-1:0] w;
      c = (vfid + k) % NC;
      w = {8'hA0 + 8'(c), 8'h00, widx[c]};
      widx[c] = widx[c] + 16'd1;
      chq[c].push_back(w);
      expq.push_back({(k == len), keep_of(c), w});
    end
  endtask

  task automatic clear_bench();
    seq.delete();
    expq.delete();
    for (int c = 0; c < NC; c++) begin
      chq[c].delete();
      pop_pend[c]  = 1'b0;
      ch_tvalid[c] = 1'b0;
    end
    act_left     = 0;
    exp_done_cyc = -1;
    prev_stall   = 1'b0;
  endtask

  task automatic start_test();
    done_cnt       = 0;
    beats          = 0;
    pops           = 0;
    first_pop_cyc  = -1;
    last_pop_cyc   = -1;
    first_mval_cyc = -1;
    for (int c = 0; c < NC; c++) trdy_seen[c] = 1'b0;
  endtask

  // Drive one cycle after the edge, then sample everything at the falling edge.
  task automatic tick();
    @(posedge aclk);
    #1;
    for (int c = 0; c < NC; c++) begin
      if (pop_pend[c] && chq[c].size() > 0) chq[c].delete(0);
      if (!(ch_tvalid[c] && !pop_pend[c]))
        ch_tvalid[c] = (chq[c].size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
      pop_pend[c] = 1'b0;
      if (chq[c].size() > 0) ch_tdata[c] = chq[c][0];
      ch_tkeep[c] = keep_of(c);
      ch_tlast[c] = ($urandom_range(0, 1) == 1);
    end
    m_axis_tready = rnd_rdy ? ($urandom_range(0, 9) >= 3) : 1'b1;
    s_mux_valid = (seq.size() > 0);
    if (seq.size() > 0) begin
      s_mux_ctl  = seq[0].ctl;
      s_mux_vfid = seq[0].vfid;
      s_mux_len  = seq[0].len;
    end
    @(negedge aclk);
    cyc++;
    if (s_mux_valid && s_mux_ready) begin
      act_left      = int'(seq[0].len) + 1;
      act_len       = int'(seq[0].len);
      act_ctl       = seq[0].ctl;
      b2b_acc_cyc   = cyc;
      b2b_prev_last = last_pop_cyc;
      seq.delete(0);
    end
    for (int c = 0; c < NC; c++) begin
      trdy_seen[c] = trdy_seen[c] | ch_tready[c];
      if (ch_tvalid[c] && ch_tready[c]) begin
        pop_pend[c] = 1'b1;
        pops++;
        total_cnt++;
        if (act_left == 0) begin
          $display("FAIL chan_pop_outside_request: ch=%0d got pop, expected none", c);
        end else begin
          pass_cnt++;
          if (act_left == act_len + 1) first_pop_cyc = cyc;
          act_left--;
          if (act_left == 0) begin
            last_pop_cyc = cyc;
            if (act_ctl) exp_done_cyc = cyc + 1;
          end
        end
      end
    end
    if (!areset && prev_stall) begin
      total_cnt++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== {1'b1, prev_word})
        $display("FAIL stall_stability: got %h, expected %h",
                 {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, {1'b1, prev_word});
      else pass_cnt++;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      beats++;
      total_cnt++;
      if (expq.size() == 0) begin
        $display("FAIL m_axis_extra_beat: got %h, expected no beat",
                 {m_axis_tlast, m_axis_tkeep, m_axis_tdata});
      end else begin
        logic [36:0] e;
        e = expq.pop_front();
        if ({m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== e)
          $display("FAIL m_axis_beat: got %h, expected %h",
                   {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, e);
        else pass_cnt++;
      end
    end
    if (first_mval_cyc < 0 && m_axis_tvalid) first_mval_cyc = cyc;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_word  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    if (s_mux_done) begin
      done_cnt++;
      total_cnt++;
      if (cyc !== exp_done_cyc)
        $display("FAIL done_timing: got done at cycle %0d, expected cycle %0d", cyc, exp_done_cyc);
      else pass_cnt++;
      exp_done_cyc = -1;
    end
  endtask

  task automatic run_idle(input int maxc, output bit to);
    int n;
    n = 0;
    while ((seq.size() != 0 || act_left != 0 || expq.size() != 0) && n < maxc) begin
      tick();
      n++;
    end
    tick();
    tick();
    to = (n >= maxc);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({s_mux_ready, m_axis_tvalid, s_mux_done} !== 3'b000)
      $display("FAIL reset_hold: got ready/tvalid/done=%b, expected 000",
               {s_mux_ready, m_axis_tvalid, s_mux_done});
    else pass_cnt++;
    areset = 1'b0;
    tick();
    total_cnt++;
    if (s_mux_ready !== 1'b1)
      $display("FAIL reset_ready_after: got %b, expected 1", s_mux_ready);
    else pass_cnt++;
    total_cnt++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, s_mux_done, trdy_vec} !== '0)
      $display("FAIL reset_outputs_zero: got %h, expected 0",
               {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, s_mux_done, trdy_vec});
    else pass_cnt++;
  endtask

  task automatic test_aligned();
    bit to;
    start_test();
    push_req(1'b1, 0, 7);
    run_idle(200, to);
    total_cnt++;
    if (to) $display("FAIL aligned_timeout: got timeout, expected completion");
    else pass_cnt++;
    total_cnt++;
    if (beats !== 8) $display("FAIL aligned_beats: got %0d, expected 8", beats);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== 1) $display("FAIL aligned_done_count: got %0d, expected 1", done_cnt);
    else pass_cnt++;
    total_cnt++;
    if (last_pop_cyc - first_pop_cyc !== 7)
      $display("FAIL aligned_throughput: got span %0d, expected 7", last_pop_cyc - first_pop_cyc);
    else pass_cnt++;
    total_cnt++;
    if (first_mval_cyc !== first_pop_cyc + 1)
      $display("FAIL aligned_latency: got cycle %0d, expected %0d", first_mval_cyc, first_pop_cyc + 1);
    else pass_cnt++;
  endtask

  task automatic test_unaligned_wrap();
    bit to;
    start_test();
    chq[2].push_back(32'hDEAD0002);
    push_req(1'b1, 3, 2);
    run_idle(200, to);
    total_cnt++;
    if (to) $display("FAIL wrap_timeout: got timeout, expected completion");
    else pass_cnt++;
    total_cnt++;
    if (trdy_seen[2] !== 1'b0) $display("FAIL wrap_ch2_tready: got %b, expected 0", trdy_seen[2]);
    else pass_cnt++;
    total_cnt++;
    if (chq[2].size() !== 1) $display("FAIL wrap_ch2_stalled: got %0d left, expected 1", chq[2].size());
    else pass_cnt++;
    total_cnt++;
    if ({beats, done_cnt} !== {32'd3, 32'd1})
      $display("FAIL wrap_counts: got beats=%0d done=%0d, expected beats=3 done=1", beats, done_cnt);
    else pass_cnt++;
    chq[2].delete();
  endtask

  task automatic test_single_beat();
    bit to;
    start_test();
    push_req(1'b0, 2, 0);
    run_idle(100, to);
    total_cnt++;
    if (to) $display("FAIL single_timeout: got timeout, expected completion");
    else pass_cnt++;
    total_cnt++;
    if ({beats, done_cnt} !== {32'd1, 32'd0})
      $display("FAIL single_counts: got beats=%0d done=%0d, expected beats=1 done=0", beats, done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit to;
    start_test();
    gaps    = 1'b1;
    rnd_rdy = 1'b1;
    push_req(1'b1, 1, 5);
    push_req(1'b1, 0, 3);
    push_req(1'b1, 2, 9);
    run_idle(3000, to);
    gaps    = 1'b0;
    rnd_rdy = 1'b0;
    tick();
    total_cnt++;
    if (to) $display("FAIL bp_timeout: got timeout, expected completion");
    else pass_cnt++;
    total_cnt++;
    if (beats !== 20) $display("FAIL bp_beats: got %0d, expected 20", beats);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== 3) $display("FAIL bp_done_count: got %0d, expected 3", done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    start_test();
    push_req(1'b1, 0, 7);
    n = 0;
    while (pops < 3 && n < 100) begin
      tick();
      n++;
    end
    total_cnt++;
    if (pops < 3) $display("FAIL rstmid_progress: got %0d pops, expected 3", pops);
    else pass_cnt++;
    areset = 1'b1;
    tick();
    total_cnt++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, s_mux_done, s_mux_ready, trdy_vec} !== '0)
      $display("FAIL rstmid_outputs_zero: got %h, expected 0",
               {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, s_mux_done, s_mux_ready, trdy_vec});
    else pass_cnt++;
    clear_bench();
    areset = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({m_axis_tvalid, done_cnt} !== {1'b0, 32'd0})
      $display("FAIL rstmid_flushed: got tvalid=%b done=%0d, expected tvalid=0 done=0",
               m_axis_tvalid, done_cnt);
    else pass_cnt++;
    start_test();
    push_req(1'b1, 1, 3);
    run_idle(200, to);
    total_cnt++;
    if (to || beats !== 4 || done_cnt !== 1)
      $display("FAIL rstmid_followup: got to=%0d beats=%0d done=%0d, expected to=0 beats=4 done=1",
               to, beats, done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit to;
    start_test();
    push_req(1'b1, 0, 3);
    push_req(1'b1, 2, 1);
    run_idle(200, to);
    total_cnt++;
    if (to) $display("FAIL b2b_timeout: got timeout, expected completion");
    else pass_cnt++;
    total_cnt++;
    if (b2b_acc_cyc !== b2b_prev_last + 1)
      $display("FAIL b2b_accept_cycle: got %0d, expected %0d", b2b_acc_cyc, b2b_prev_last + 1);
    else pass_cnt++;
    total_cnt++;
    if (first_pop_cyc !== b2b_prev_last + 2)
      $display("FAIL b2b_bubble: got first beat at %0d, expected %0d", first_pop_cyc, b2b_prev_last + 2);
    else pass_cnt++;
    total_cnt++;
    if ({beats, done_cnt} !== {32'd6, 32'd2})
      $display("FAIL b2b_counts: got beats=%0d done=%0d, expected beats=6 done=2", beats, done_cnt);
    else pass_cnt++;
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      widx[c]      = 16'd0;
      ch_tdata[c]  = '0;
      ch_tkeep[c]  = '0;
      ch_tlast[c]  = 1'b0;
      ch_tvalid[c] = 1'b0;
      pop_pend[c]  = 1'b0;
      trdy_seen[c] = 1'b0;
    end
    test_reset();
    test_aligned();
    test_unaligned_wrap();
    test_single_beat();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cdma_stripe_mux.md
# cdma_stripe_mux

Read-side reassembly for striped CDMA transfers. It consumes the per-request sequence entries (`ctl`, `vfid`, `len`) produced by the stripe request adjuster. It then merges the N_MEM_CHAN per-channel DDR read streams into one AXI stream in beat-interleaved order, starting at channel `vfid`. On completion of every request with `ctl` set, it returns a `done` pulse toward the CDMA issuer. It sits between the per-channel CDMA read data streams and the card-side host/user stream.

## Interface
- `N_CHAN`, default `N_MEM_CHAN`: number of striped channels; power of two, ≥2.
- `DATA_BITS`, default `AXI_DATA_BITS`: stream data width.
- `BLEN_BITS`, default `LEN_BITS - $clog2(DATA_BITS/8)`: beat-count width.
- `aclk`  in  1: single clock for the whole block.
- `areset`  in  1: reset, synchronous and active-high.
- `s_mux_valid`  in  1: sequence entry valid.
- `s_mux_ready`  out  1: sequence entry accepted.
- `s_mux_ctl`  in  1: request wants a completion.
- `s_mux_vfid`  in  N_MEM_CHAN_BITS: starting channel.
- `s_mux_len`  in  BLEN_BITS: total beats minus 1.
- `s_mux_done`  out  1: one-cycle completion pulse.
- `s_axis_chan_tdata[N_CHAN]`  in  DATA_BITS: per-channel read data.
- `s_axis_chan_tkeep[N_CHAN]`  in  DATA_BITS/8: per-channel byte enables.
- `s_axis_chan_tlast[N_CHAN]`  in  1: per-channel last; ignored.
- `s_axis_chan_tvalid[N_CHAN]`  in  1: per-channel valid.
- `s_axis_chan_tready[N_CHAN]`  out  1: per-channel ready.
- `m_axis_tdata`  out  DATA_BITS: merged stream data.
- `m_axis_tkeep`  out  DATA_BITS/8: merged stream byte enables.
- `m_axis_tlast`  out  1: last beat of the request.
- `m_axis_tvalid`  out  1: merged stream valid.
- `m_axis_tready`  in  1: merged stream ready.

## Operation
- FSM states: IDLE, XFER.
- IDLE: `s_mux_ready`=1. On `s_mux_valid`:
  - Load `ptr`←`vfid`, `cnt`←`len`, `ctl_r`←`ctl`.
  - Go to XFER.
- XFER: `s_mux_ready`=0. Only channel `ptr` is selected.
  - `s_axis_chan_tready[ptr]` = skid input ready; all other channels get tready=0.
  - The selected beat's tdata/tkeep go into the skid stage.
  - Its tlast bit is set to (`cnt`==0); the channel's own tlast is discarded.
- On each accepted channel beat:
  - `ptr`←`ptr`+1, modulo N_CHAN (natural wrap of the N_MEM_CHAN_BITS counter).
  - `cnt`←`cnt`−1.
- Accepted beat with `cnt`==0:
  - Return to IDLE.
  - If `ctl_r`, assert `s_mux_done` for exactly one cycle, on the next cycle.
- A request of `len`+1 beats takes exactly `len`+1 channel beats, in the order vfid, vfid+1, … mod N_CHAN.
- Unequal per-channel beat counts are inherent to striping. The block never inspects channel tlast.
- Channel valids that arrive early on non-selected channels stay stalled. No reordering, no dropping.

## Timing
- Reset values: `s_mux_ready`=0 during reset, 1 on the first cycle after. All other outputs are 0. State IDLE, `ptr`/`cnt`/`ctl_r` = 0, skid empty.
- Reset mid-XFER: the skid is flushed and no `done` is issued. Beats already emitted stand. Any partially consumed channel data is the upstream's responsibility, since all channels are reset together.
- Latency: channel beat to `m_axis_tvalid` is 1 cycle (registered skid).
- Throughput: 1 beat/cycle under full readiness.
- Per request: one IDLE cycle, i.e. a one-cycle bubble between back-to-back requests.
- `m_axis` obeys AXI-stream rules. tdata/tkeep/tlast/tvalid stay stable while tvalid=1 and tready=0.
- The skid holds 2 entries. Its input ready depends only on registered occupancy, so there is no combinational `m_axis_tready`→`s_axis_chan_tready` path.
- `done` is raised the cycle after the last beat enters the skid. It may precede that beat leaving on `m_axis`.
- `len`=0: single beat, tlast on it. If `vfid`=N_CHAN−1, `ptr` wraps to 0 while returning to IDLE; this is harmless.

## Structure
- `N_MEM_CHAN`, `N_MEM_CHAN_BITS`, `AXI_DATA_BITS`, `LEN_BITS` come from `lynxTypes`.
- Add to `lynxTypes`:
  - a `stripe_seq_t` struct {ctl, vfid, len};
  - a `stripe_fsm_t` enum {IDLE, XFER}.
- One sub-module: `cdma_stripe_skid`, a 2-entry AXI-stream register slice over {tdata, tkeep, tlast}.

## Test plan
All scenarios use N_CHAN=4.
- **Aligned 8-beat request.** Inputs: vfid=0, len=7, ctl=1, channels always valid. Required: m_axis carries beats from ch0,1,2,3,0,1,2,3; tlast only on beat 8; exactly one `done`, one cycle after beat 8 is accepted.
- **Unaligned wrap.** Inputs: vfid=3, len=2, ctl=1. Required: beats from ch3, ch0, ch1; ch2 tready never asserted; tlast on the ch1 beat; `done` pulses once.
- **Single beat, no completion.** Inputs: vfid=2, len=0, ctl=0. Required: one beat with tlast=1; `s_mux_done` stays 0.
- **Backpressure and gaps.** Inputs: random `m_axis_tready` at 30% low; random channel valid gaps; three queued requests (vfid 1/0/2, len 5/3/9). Required: data order matches the scoreboard; no duplicated or lost beats; stability held under stall; three `done` pulses.
- **Reset mid-transfer.** Inputs: areset after 3 of 8 beats. Required: next cycle all outputs are 0 and the skid is empty; no `done`. A following request with vfid=1, len=3 completes correctly.
- **Back-to-back.** Inputs: a second entry presented while the first is in XFER. Required: the second is accepted in the IDLE cycle immediately after the first's last beat, with exactly one bubble cycle.
